shift_unit: RTL
===============

Name: shift_unit

Overview:
- Multi-cycle barrel-shift replacement that sits beside the per-bit ALU slice array, downstream of operand selection. Implements the shift opcodes the bit-slice ALU does not cover: SLL, SRL and SRA.
- Its result feeds the same result mux as the slice array.
- Shifts one bit per clock under a start/busy/done handshake. This keeps area small for the single-cycle core; the core stalls while the unit is busy.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, $clog2(WIDTH) (5), width of the shift amount.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  request; sampled only while busy_o=0.
- operacion_i  input  4  opcode: 4'b0110 SLL, 4'b0111 SRL, 4'b1000 SRA.
- a_i  input  WIDTH  operand to shift.
- shamt_i  input  SHAMT_W  shift amount, 0..WIDTH-1.
- resultado_o  output  WIDTH  last completed result; registered.
- busy_o  output  1  high while a shift is in progress.
- done_o  output  1  one-cycle pulse: resultado_o is newly valid.
- illegal_o  output  1  one-cycle pulse with done_o when the accepted opcode was not a shift.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
  - On reset: state=IDLE; resultado_o=0, busy_o=0, done_o=0, illegal_o=0; internal shift register and counter cleared.
  - Reset wins over every other event, including a mid-shift operation. The partial result is discarded and resultado_o returns to 0.
- Internal registers: sreg (WIDTH), cnt (SHAMT_W), op (4), fill (1).
- States: IDLE, SHIFT, DONE.
- Accept: at a rising edge with start_i=1 and state in {IDLE, DONE}:
  - latch sreg=a_i, cnt=shamt_i, op=operacion_i, fill=a_i[WIDTH-1].
  - If the opcode is not a shift: next state is DONE; resultado_o=0 and illegal_o=1 in the DONE cycle.
  - Else if shamt_i=0: next state is DONE with resultado_o=a_i.
  - Otherwise next state is SHIFT.
- SHIFT: each edge moves sreg by one position and decrements cnt.
  - SLL: left shift, 0 shifted in at the LSB.
  - SRL: right shift, 0 shifted in at the MSB.
  - SRA: right shift, fill shifted in at the MSB.
  - On the edge where cnt goes 1->0: next state is DONE and resultado_o is loaded with the final sreg value.
- DONE: lasts one cycle; done_o=1. Next state is IDLE, or SHIFT/DONE if a new start is accepted in this cycle (back-to-back operation).
- busy_o = (state==SHIFT). start_i while busy is ignored; no queueing.
- Latency: start_i high in cycle 0 -> done_o high in cycle shamt+1 (shamt=0: cycle 1; shamt=31: cycle 32).
- resultado_o changes only on entry to DONE or on reset. It holds its value through IDLE and through later SHIFT cycles until the next completion.
- Inputs a_i, shamt_i and operacion_i are don't-care except in the accept cycle.
- shamt_i is unsigned, with no wrap-around beyond SHAMT_W bits.

Optional Feature:
- Macro: SHIFT_FAST4_EN.
- When defined, a SHIFT cycle with cnt>=4 moves 4 positions and subtracts 4; a cycle with cnt<4 moves 1 position. Fill rules per opcode are unchanged.
- Latency becomes floor(shamt/4) + shamt%4 + 1 cycles from start to done_o; shamt=31 gives done in cycle 11.
- When not defined, the unit is strictly 1 bit per cycle, as above.
- Results are identical with and without the macro.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SLT=4'b0011, ALU_XOR=4'b0100, ALU_SLTU=4'b0101, ALU_SLL=4'b0110, ALU_SRL=4'b0111, ALU_SRA=4'b1000;
  - the shift-state enum (IDLE/SHIFT/DONE).
- The ALU slice decoder reuses the same opcode constants.
- One combinational sub-module, shift_step, is natural: it takes sreg, op, fill and a step select (1 or 4) and returns the next sreg.

Test Plan:
- Reset then idle: resultado_o=0, busy_o=0, done_o=0 for 3 cycles.
- SLL, a_i=32'h0000_0001, shamt=31 -> done_o only in cycle 32, resultado_o=32'h8000_0000, busy_o high in cycles 1..31.
- SRA, a_i=32'h8000_0000, shamt=4 -> resultado_o=32'hF800_0000 in cycle 5. SRL with the same stimulus -> 32'h0800_0000.
- SLL, shamt=0, a_i=32'hDEAD_BEEF -> done_o in cycle 1, resultado_o=32'hDEAD_BEEF.
- Start pulses during busy_o=1 with different a_i -> ignored; the original result is delivered. A back-to-back start in the DONE cycle -> second op accepted, second done pulse at its own latency.
- rst_i asserted mid-SRL at cycle 3 -> next cycle IDLE, resultado_o=0, no done_o pulse. Opcode 4'b0010 accepted -> done_o and illegal_o in cycle 1, resultado_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode constants shared by the ALU slice decoder and the shift unit,
// plus the shift unit's state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One shift step of the shift unit: moves sreg by 1 or 4 positions
// according to the latched opcode, using fill as the SRA sign bit.
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] sreg_i,
  input  logic [3:0]       op_i,
  input  logic             fill_i,
  input  logic             step4_i,
  output logic [WIDTH-1:0] sreg_o
);

  always_comb begin
    sreg_o = sreg_i;
    case (op_i)
      ALU_SLL: sreg_o = step4_i ? {sreg_i[WIDTH-5:0], 4'b0000}
                                : {sreg_i[WIDTH-2:0], 1'b0};
      ALU_SRL: sreg_o = step4_i ? {4'b0000, sreg_i[WIDTH-1:4]}
                                : {1'b0, sreg_i[WIDTH-1:1]};
      ALU_SRA: sreg_o = step4_i ? {{4{fill_i}}, sreg_i[WIDTH-1:4]}
                                : {fill_i, sreg_i[WIDTH-1:1]};
      default: sreg_o = sreg_i;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit with start/busy/done handshake.
// Define SHIFT_FAST4_EN to move 4 positions per cycle while cnt >= 4.
//
// state | meaning
// IDLE  | waiting for start_i
// SHIFT | shifting sreg, cnt positions left to go
// DONE  | resultado_o newly valid, done_o high; may accept a new start
module shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         operacion_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   resultado_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               illegal_o
);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ill_q, ill_d;

  logic               step4;
  logic [SHAMT_W-1:0] cnt_step;
  logic [WIDTH-1:0]   sreg_nxt;

`ifdef SHIFT_FAST4_EN
  assign step4 = (cnt_q >= SHAMT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign cnt_step = step4 ? SHAMT_W'(4) : SHAMT_W'(1);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .sreg_i  (sreg_q),
    .op_i    (op_q),
    .fill_i  (fill_q),
    .step4_i (step4),
    .sreg_o  (sreg_nxt)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    res_d   = res_q;
    ill_d   = 1'b0;
    case (state_q)
      SHIFT: begin
        sreg_d = sreg_nxt;
        cnt_d  = cnt_q - cnt_step;
        if (cnt_d == '0) begin
          state_d = DONE;
          res_d   = sreg_nxt;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          sreg_d = a_i;
          cnt_d  = shamt_i;
          op_d   = operacion_i;
          fill_d = a_i[WIDTH-1];
          if (!is_shift_op(operacion_i)) begin
            state_d = DONE;
            res_d   = '0;
            ill_d   = 1'b1;
          end else if (shamt_i == '0) begin
            state_d = DONE;
            res_d   = a_i;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  assign resultado_o = res_q;
  assign busy_o      = (state_q == SHIFT);
  assign done_o      = (state_q == DONE);
  assign illegal_o   = ill_q;

endmodule
